mx_int8_block_negate_rx: RTL and testbench
==========================================

// Module: mx_int8_block_negate_rx
// PURPOSE
//  Receiving end of the MXINT8 block-driver interface. Latches a full parallel MXINT8
//  element vector when data_ready_i pulses. Replays it as a serial stream, one element
//  per cycle, each element negated with saturation. Reports per-block zero and
//  saturation counts. Sits between the block driver and the scalar MXINT8 datapath.
// PARAMETERS
//  BLOCK_SIZE     32  elements per MX block (>=2)
//  ELEM_WIDTH      8  MXINT8 element width, two's complement
// PORTS
//  clk            in   1                       clock, all state on rising edge
//  rst_n          in   1                       reset, asynchronous assert, active-low
//  data_ready_i   in   1                       1-cycle pulse: elements_i valid this cycle
//  elements_i     in   BLOCK_SIZE*ELEM_WIDTH   packed [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0]; element 0 in MS bits
//  elem_valid_o   out  1                       elem_o/elem_idx_o valid this cycle
//  elem_o         out  ELEM_WIDTH              negated (saturated) element
//  elem_idx_o     out  $clog2(BLOCK_SIZE)      index of elem_o within block
//  block_done_o   out  1                       pulse with last element of block
//  busy_o         out  1                       streaming in progress
//  zero_cnt_o     out  $clog2(BLOCK_SIZE)+1    zero elements in last completed block
//  sat_cnt_o      out  $clog2(BLOCK_SIZE)+1    saturated elements (input 0x80) in last completed block
//  overrun_o      out  1                       pulse: data_ready_i dropped because busy
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, idx=0.
//    All outputs 0: elem_valid_o, elem_o, elem_idx_o, block_done_o, busy_o,
//    zero_cnt_o, sat_cnt_o, overrun_o. Capture register cleared.
//  - FSM: IDLE, STREAM.
//    IDLE: data_ready_i=1 -> capture elements_i, idx<=0, go STREAM.
//    STREAM: each cycle present element idx, then idx++.
//    At idx==BLOCK_SIZE-1: if data_ready_i=1, recapture, idx<=0 and stay STREAM
//    (back-to-back); otherwise go IDLE.
//  - Latency: pulse sampled at edge T -> element 0 registered at T+1.
//    Element k is valid in the cycle after edge T+1+k.
//    The block completes in exactly BLOCK_SIZE valid cycles, with no gaps.
//  - Accept rule: pulse accepted only in IDLE or on the last STREAM cycle.
//    A pulse at any other time is dropped. overrun_o=1 for one cycle.
//    The current block continues unaffected.
//  - Arithmetic: elem_o = -x in two's complement.
//    x=0x80 (-128) saturates to 0x7F and counts as saturated.
//    x=0x00 -> 0x00 and counts as zero. No other input saturates.
//  - elem_o and elem_idx_o are registered. Both hold their last value when
//    elem_valid_o=0. busy_o = (state==STREAM).
//  - block_done_o is high on the same cycle as the element with idx BLOCK_SIZE-1.
//  - zero_cnt_o and sat_cnt_o update on that same cycle, with totals that include the
//    last element. They hold until the next block completes.
//    Running accumulators clear on each accept.
//  - elements_i is sampled only on an accepted pulse. Input changes after capture
//    do not affect the stream.
//  - rst_n asserted mid-block: stream aborts immediately, all outputs return to reset
//    values, no block_done_o. First pulse after release starts a fresh block.
// TESTING
//  1. Reset, one block with element k = k+1 (BLOCK_SIZE=32)
//     -> 32 valid cycles, elem_o = -(k+1) (0xFF, 0xFE, ...),
//     block_done_o at idx 31, zero_cnt_o=0, sat_cnt_o=0.
//  2. Block with element 5 = 0x00 and element 9 = 0x80, others 0x01
//     -> elem_o[5]=0x00, elem_o[9]=0x7F, others 0xFF;
//     zero_cnt_o=1, sat_cnt_o=1 after done.
//  3. Second pulse 4 cycles into a block
//     -> overrun_o single pulse, first block completes intact, second block not streamed.
//  4. Pulse on last STREAM cycle with new data
//     -> 64 consecutive valid cycles, idx wraps 31->0, two block_done_o pulses,
//     counts reflect each block separately.
//  5. All elements 0x80 -> all outputs 0x7F, sat_cnt_o=32.
//     All elements 0x00 -> zero_cnt_o=32.
//  6. rst_n low at idx 10 -> outputs 0 asynchronously, no block_done_o;
//     next pulse yields full 32-element block from idx 0.

Source files
------------

// File: rtl/mx_int8_block_negate_rx.sv
// mx_int8_block_negate_rx: latch a parallel MXINT8 block and replay it serially, negated with saturation
module mx_int8_block_negate_rx #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             data_ready_i,
    input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements_i,
    output logic                             elem_valid_o,
    output logic [ELEM_WIDTH-1:0]            elem_o,
    output logic [$clog2(BLOCK_SIZE)-1:0]    elem_idx_o,
    output logic                             block_done_o,
    output logic                             busy_o,
    output logic [$clog2(BLOCK_SIZE):0]      zero_cnt_o,
    output logic [$clog2(BLOCK_SIZE):0]      sat_cnt_o,
    output logic                             overrun_o
);
    localparam int IW = $clog2(BLOCK_SIZE);
    localparam int CW = IW + 1;
    localparam logic [ELEM_WIDTH-1:0] MIN_VAL = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
    localparam logic [ELEM_WIDTH-1:0] MAX_VAL = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] cap;
    logic [ELEM_WIDTH-1:0] x, neg;
    logic [CW-1:0] zacc, sacc;
    logic last, accept, is_zero, is_sat;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = accept ? STREAM : (last ? IDLE : state);
    always_comb begin
        busy_o  = state == STREAM;
        last    = busy_o && idx == IW'(BLOCK_SIZE-1);
        accept  = data_ready_i && (state == IDLE || last);
        x       = cap[ELEM_WIDTH*(BLOCK_SIZE-1-int'(idx)) +: ELEM_WIDTH];
        is_sat  = x == MIN_VAL;
        is_zero = x == '0;
        neg     = is_sat ? MAX_VAL : -x;
    end
    // a pulse on the last element both closes the counts and reopens the accumulators
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cap          <= '0;
            idx          <= '0;
            zacc         <= '0;
            sacc         <= '0;
            elem_valid_o <= 1'b0;
            elem_o       <= '0;
            elem_idx_o   <= '0;
            block_done_o <= 1'b0;
            zero_cnt_o   <= '0;
            sat_cnt_o    <= '0;
            overrun_o    <= 1'b0;
        end else begin
            elem_valid_o <= busy_o;
            block_done_o <= last;
            overrun_o    <= data_ready_i && !accept;
            if (busy_o) begin
                elem_o     <= neg;
                elem_idx_o <= idx;
            end
            if (last) begin
                zero_cnt_o <= zacc + CW'(is_zero);
                sat_cnt_o  <= sacc + CW'(is_sat);
            end
            if (accept) begin
                cap  <= elements_i;
                idx  <= '0;
                zacc <= '0;
                sacc <= '0;
            end else if (busy_o) begin
                idx  <= last ? '0 : idx + 1'b1;
                zacc <= zacc + CW'(is_zero);
                sacc <= sacc + CW'(is_sat);
            end
        end
endmodule

// File: tb/tb_mx_int8_block_negate_rx.sv
// tb_mx_int8_block_negate_rx: directed scoreboard bench for the MXINT8 negating block receiver
module tb_mx_int8_block_negate_rx;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         data_ready_i = 1'b0;
    logic [255:0] elements_i = '0;
    logic         elem_valid_o, block_done_o, busy_o, overrun_o;
    logic [7:0]   elem_o;
    logic [4:0]   elem_idx_o;
    logic [5:0]   zero_cnt_o, sat_cnt_o;

    typedef struct {
        logic [7:0] elem;
        int         idx;
        int         zc;
        int         sc;
    } exp_t;
    exp_t q[$];
    int nvec = 0, nfail = 0;
    int run = 0, max_run = 0;
    bit prev_valid = 0;
    int prev_idx = 0;
    logic [255:0] blk, blk2;

    mx_int8_block_negate_rx dut (
        .clk(clk), .rst_n(rst_n), .data_ready_i(data_ready_i), .elements_i(elements_i),
        .elem_valid_o(elem_valid_o), .elem_o(elem_o), .elem_idx_o(elem_idx_o),
        .block_done_o(block_done_o), .busy_o(busy_o), .zero_cnt_o(zero_cnt_o),
        .sat_cnt_o(sat_cnt_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_neg(input logic [7:0] x);
        int v;
        v = -int'($signed(x));
        if (v > 127) v = 127;
        return v[7:0];
    endfunction

    // drives a one-cycle pulse; an accepted block queues its 32 expected elements
    task automatic pulse(input logic [255:0] b, input bit accepted);
        int zc = 0, sc = 0;
        logic [7:0] e;
        @(posedge clk) #1;
        data_ready_i = 1'b1;
        elements_i = b;
        if (accepted)
            for (int k = 0; k < 32; k++) begin
                e = b[(31-k)*8 +: 8];
                zc += int'(e == 8'h00);
                sc += int'(e == 8'h80);
                q.push_back('{ref_neg(e), k, zc, sc});
            end
        @(posedge clk) #1;
        data_ready_i = 1'b0;
        elements_i = {8{$urandom}};
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && (q.size() != 0 || busy_o); i++) @(posedge clk) #1;
        check("drain_timeout", i < 300, 1);
        check("drain_left", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && prev_idx != 31) check("gap", elem_valid_o, 1);
            if (elem_valid_o) begin
                exp_t e;
                run++;
                if (run > max_run) max_run = run;
                check("spurious", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("elem", elem_o, e.elem);
                    check("idx", elem_idx_o, e.idx);
                    check("done", block_done_o, e.idx == 31);
                    if (e.idx == 31) begin
                        check("zero_cnt", zero_cnt_o, e.zc);
                        check("sat_cnt", sat_cnt_o, e.sc);
                    end
                end
            end else begin
                run = 0;
                check("done_idle", block_done_o, 0);
            end
        end else run = 0;
        prev_valid = elem_valid_o && rst_n;
        prev_idx = elem_idx_o;
    end

    initial begin
        int i;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", elem_valid_o, 0);
        check("rst_elem", elem_o, 0);
        check("rst_idx", elem_idx_o, 0);
        check("rst_done", block_done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_zero", zero_cnt_o, 0);
        check("rst_sat", sat_cnt_o, 0);
        check("rst_overrun", overrun_o, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = 8'(k + 1);
        pulse(blk, 1);
        check("busy_after_accept", busy_o, 1);
        drain();
        check("t1_zero_hold", zero_cnt_o, 0);

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = 8'h01;
        blk[(31-5)*8 +: 8] = 8'h00;
        blk[(31-9)*8 +: 8] = 8'h80;
        pulse(blk, 1);
        drain();
        check("t2_zero_hold", zero_cnt_o, 1);
        check("t2_sat_hold", sat_cnt_o, 1);

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 32; k++) blk2[(31-k)*8 +: 8] = 8'h80;
        pulse(blk, 1);
        repeat (3) @(posedge clk);
        pulse(blk2, 0);
        check("overrun_pulse", overrun_o, 1);
        @(posedge clk) #1;
        check("overrun_single", overrun_o, 0);
        drain();
        repeat (3) @(posedge clk) #1;
        check("dropped_not_streamed", elem_valid_o, 0);

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = (k % 3 == 0) ? 8'h00 : 8'(k * 7);
        for (int k = 0; k < 32; k++) blk2[(31-k)*8 +: 8] = (k % 4 == 1) ? 8'h80 : 8'($urandom_range(1, 127));
        max_run = 0;
        pulse(blk, 1);
        repeat (30) @(posedge clk);
        pulse(blk2, 1);
        check("b2b_no_overrun", overrun_o, 0);
        drain();
        check("b2b_run64", max_run, 64);
        check("b2b_sat_hold", sat_cnt_o, 8);
        check("b2b_zero_hold", zero_cnt_o, 0);

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = 8'h80;
        pulse(blk, 1);
        drain();
        check("all80_sat", sat_cnt_o, 32);
        blk = '0;
        pulse(blk, 1);
        drain();
        check("all00_zero", zero_cnt_o, 32);
        check("all00_sat", sat_cnt_o, 0);

        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = 8'(8'h40 - k);
        pulse(blk, 1);
        for (i = 0; i < 100 && !(elem_valid_o && elem_idx_o == 5'd10); i++) @(negedge clk);
        check("reach_idx10", i < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", elem_valid_o, 0);
        check("arst_elem", elem_o, 0);
        check("arst_idx", elem_idx_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_zero", zero_cnt_o, 0);
        check("arst_sat", sat_cnt_o, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 check("arst_no_done", block_done_o, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 32; k++) blk[(31-k)*8 +: 8] = (k == 0) ? 8'h80 : 8'(k);
        pulse(blk, 1);
        drain();
        check("post_rst_sat", sat_cnt_o, 1);
        check("post_rst_zero", zero_cnt_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
